regfile_writeback: RTL and testbench

Write-back stage that owns the single write port of the 16-bit, 8-entry register file. It accepts results from the single-cycle ALU path and the variable-latency load path, and buffers load results in a small FIFO. It arbitrates between the two sources and drives the register file's write-enable/address/data from registers. It also keeps a per-register pending-write scoreboard that the decode/hazard logic uses to stall reads of registers not yet written.

---
 rtl/regfile_writeback.sv | 145 ++++++++++++++
 tb/tb_regfile_writeback.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Write-back stage: merges single-cycle ALU results with buffered load results onto the
// register file write port, and tracks outstanding writes per register for hazard stalls.
module regfile_writeback #(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 3,
   parameter int LQ_DEPTH     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      issue_valid,
   input  logic [ADDR_W-1:0]         issue_addr,
   output logic                      issue_ready,
   input  logic                      alu_valid,
   output logic                      alu_ready,
   input  logic [ADDR_W-1:0]         alu_addr,
   input  logic [DATA_W-1:0]         alu_data,
   input  logic                      ld_valid,
   output logic                      ld_ready,
   input  logic [ADDR_W-1:0]         ld_addr,
   input  logic [DATA_W-1:0]         ld_data,
   output logic                      rf_we,
   output logic [ADDR_W-1:0]         rf_wr,
   output logic [DATA_W-1:0]         rf_wd,
   output logic [2**ADDR_W-1:0]      busy,
   output logic [$clog2(LQ_DEPTH):0] lq_count,
   output logic                      wb_err
);

   localparam int NREGS = 2**ADDR_W;
   localparam int CW    = $clog2(LQ_DEPTH) + 1;
   localparam int PW    = $clog2(LQ_DEPTH);
   localparam int SW    = $clog2(STARVE_LIMIT + 1);

   logic [ADDR_W+DATA_W-1:0] lq_mem [LQ_DEPTH];
   logic [PW-1:0]            lq_wptr;
   logic [PW-1:0]            lq_rptr;
   logic [SW-1:0]            starve_cnt;
   logic [1:0]               pend [NREGS];

   logic lq_nonempty;
   logic force_ld;
   logic push;
   logic alu_win;
   logic pop;
   logic issue_acc;
   logic err_set;

   assign lq_nonempty = (lq_count != '0);
   assign ld_ready    = (lq_count < CW'(LQ_DEPTH));
   assign force_ld    = lq_nonempty && (starve_cnt >= SW'(STARVE_LIMIT));
   assign alu_ready   = !force_ld;
   assign push        = ld_valid && ld_ready;
   assign alu_win     = alu_valid && alu_ready;
   assign pop         = !alu_win && lq_nonempty;
   assign issue_ready = (pend[issue_addr] != 2'd3);
   assign issue_acc   = issue_valid && issue_ready;
   // A commit against an empty counter is only an error if no issue to that register offsets it
   assign err_set     = rf_we && (pend[rf_wr] == 2'd0) && !(issue_acc && (issue_addr == rf_wr));

   always_comb begin
      busy = '0;
      for (int r = 0; r < NREGS; r++) begin
         busy[r] = (pend[r] != 2'd0);
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         lq_mem[lq_wptr] <= {ld_addr, ld_data};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lq_wptr  <= '0;
         lq_rptr  <= '0;
         lq_count <= '0;
      end else begin
         if (push) begin
            lq_wptr <= lq_wptr + 1'b1;
         end
         if (pop) begin
            lq_rptr <= lq_rptr + 1'b1;
         end
         if (push && !pop) begin
            lq_count <= lq_count + 1'b1;
         end else if (pop && !push) begin
            lq_count <= lq_count - 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (!lq_nonempty || pop) begin
         starve_cnt <= '0;
      end else if (alu_win && (starve_cnt < SW'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Idle cycles drop the enable but leave address/data as they were
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rf_we <= 1'b0;
         rf_wr <= '0;
         rf_wd <= '0;
      end else if (alu_win) begin
         rf_we <= 1'b1;
         rf_wr <= alu_addr;
         rf_wd <= alu_data;
      end else if (pop) begin
         rf_we <= 1'b1;
         {rf_wr, rf_wd} <= lq_mem[lq_rptr];
      end else begin
         rf_we <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NREGS; r++) begin
            pend[r] <= 2'd0;
         end
         wb_err <= 1'b0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (issue_acc && (issue_addr == ADDR_W'(r))
                && !(rf_we && (rf_wr == ADDR_W'(r)))) begin
               pend[r] <= pend[r] + 2'd1;
            end else if (rf_we && (rf_wr == ADDR_W'(r))
                         && !(issue_acc && (issue_addr == ADDR_W'(r)))
                         && (pend[r] != 2'd0)) begin
               pend[r] <= pend[r] - 2'd1;
            end
         end
         if (err_set) begin
            wb_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: ALU path, load buffering, arbitration/starvation,
// scoreboard saturation, sticky error flag and asynchronous reset during traffic.
module tb_regfile_writeback;

   logic        clock;
   logic        reset_n;
   logic        issue_valid;
   logic [2:0]  issue_addr;
   logic        issue_ready;
   logic        alu_valid;
   logic        alu_ready;
   logic [2:0]  alu_addr;
   logic [15:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [2:0]  ld_addr;
   logic [15:0] ld_data;
   logic        rf_we;
   logic [2:0]  rf_wr;
   logic [15:0] rf_wd;
   logic [7:0]  busy;
   logic [1:0]  lq_count;
   logic        wb_err;

   int checks = 0;
   int errors = 0;

   regfile_writeback #(
      .DATA_W(16), .ADDR_W(3), .LQ_DEPTH(2), .STARVE_LIMIT(4)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
      .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd),
      .busy(busy), .lq_count(lq_count), .wb_err(wb_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid = 1'b0; issue_addr = '0;
      alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
      ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      #2 reset_n = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #2 reset_n = 1'b1;
      step();
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      apply_reset();

      // reset state
      check("rst_rf_we", rf_we, 0);
      check("rst_rf_wr", rf_wr, 0);
      check("rst_rf_wd", rf_wd, 0);
      check("rst_busy", busy, 0);
      check("rst_lq_count", lq_count, 0);
      check("rst_wb_err", wb_err, 0);
      check("rst_ld_ready", ld_ready, 1);
      check("rst_alu_ready", alu_ready, 1);
      check("rst_issue_ready", issue_ready, 1);

      // single ALU write to r3
      issue_valid = 1; issue_addr = 3;
      step();
      issue_valid = 0;
      check("alu_busy_after_issue", busy, 8'h08);
      alu_valid = 1; alu_addr = 3; alu_data = 16'hBEEF;
      step();
      alu_valid = 0;
      check("alu_rf_we", rf_we, 1);
      check("alu_rf_wr", rf_wr, 3);
      check("alu_rf_wd", rf_wd, 16'hBEEF);
      check("alu_busy_before_commit", busy, 8'h08);
      step();
      check("alu_busy_after_commit", busy, 8'h00);
      check("alu_idle_we", rf_we, 0);
      check("alu_hold_wr", rf_wr, 3);
      check("alu_hold_wd", rf_wd, 16'hBEEF);

      // load buffering r1/r2/r4; with no ALU traffic the FIFO drains one per cycle
      issue_valid = 1; issue_addr = 1; step();
      issue_addr = 2; step();
      issue_addr = 4; step();
      issue_valid = 0;
      check("ld_busy_issued", busy, 8'h16);
      ld_valid = 1; ld_addr = 1; ld_data = 16'h0011;
      step();
      check("ld_count_1", lq_count, 1);
      check("ld_we_0", rf_we, 0);
      ld_addr = 2; ld_data = 16'h0022;
      step();
      check("ld_w1_wr", rf_wr, 1);
      check("ld_w1_wd", rf_wd, 16'h0011);
      check("ld_count_pushpop", lq_count, 1);
      check("ld_ready_pushpop", ld_ready, 1);
      ld_addr = 4; ld_data = 16'h0044;
      step();
      ld_valid = 0;
      check("ld_w2_wr", rf_wr, 2);
      check("ld_w2_wd", rf_wd, 16'h0022);
      check("ld_w2_we", rf_we, 1);
      check("ld_busy_r1_done", busy, 8'h14);
      step();
      check("ld_w3_wr", rf_wr, 4);
      check("ld_w3_wd", rf_wd, 16'h0044);
      check("ld_count_empty", lq_count, 0);
      check("ld_busy_r2_done", busy, 8'h10);
      step();
      check("ld_drained_we", rf_we, 0);
      check("ld_busy_all_done", busy, 8'h00);
      check("ld_no_err", wb_err, 0);

      // scoreboard saturation on r5
      issue_valid = 1; issue_addr = 5;
      step(); step(); step();
      check("sat_issue_ready_r5", issue_ready, 0);
      issue_addr = 0;
      check("sat_issue_ready_r0", issue_ready, 1);
      issue_addr = 5;
      alu_valid = 1; alu_addr = 5; alu_data = 16'h5555;
      step();
      alu_valid = 0;
      check("sat_commit_we", rf_we, 1);
      step();
      issue_valid = 0;
      check("sat_after_commit_ready", issue_ready, 1);
      check("sat_busy_r5", busy, 8'h20);
      alu_valid = 1; alu_addr = 5; alu_data = 16'h5556;
      step();
      alu_valid = 0;
      issue_valid = 1; issue_addr = 5;
      step();
      check("sat_incdec_ready", issue_ready, 1);
      step();
      issue_valid = 0;
      check("sat_refill_ready", issue_ready, 0);
      check("sat_no_err", wb_err, 0);

      // ALU priority and load starvation
      apply_reset();
      check("stv_alu_ready_0", alu_ready, 1);
      alu_valid = 1; alu_addr = 2; alu_data = 16'hA000;
      ld_valid = 1; ld_addr = 7; ld_data = 16'h7777;
      step();
      ld_valid = 0;
      check("stv_push_wd", rf_wd, 16'hA000);
      check("stv_queued", lq_count, 1);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("stv_alu_ready_%0d", k), alu_ready, 1);
         alu_data = 16'hA000 + 16'(k);
         step();
         check($sformatf("stv_alu_wd_%0d", k), rf_wd, 32'hA000 + 32'(k));
      end
      check("stv_forced_ready", alu_ready, 0);
      alu_data = 16'hA005;
      step();
      check("stv_load_wr", rf_wr, 7);
      check("stv_load_wd", rf_wd, 16'h7777);
      check("stv_empty", lq_count, 0);
      check("stv_ready_back", alu_ready, 1);
      step();
      alu_valid = 0;
      check("stv_alu_resume_wd", rf_wd, 16'hA005);
      check("stv_err_unissued", wb_err, 1);

      // reset in the middle of traffic with the FIFO full
      apply_reset();
      issue_valid = 1; issue_addr = 7;
      step();
      issue_valid = 0;
      alu_valid = 1; alu_addr = 0; alu_data = 16'h0101;
      ld_valid = 1; ld_addr = 1; ld_data = 16'h1111;
      step();
      ld_data = 16'h2222;
      step();
      check("mid_full_count", lq_count, 2);
      check("mid_full_ready", ld_ready, 0);
      ld_data = 16'h3333;
      step();
      check("mid_no_overflow", lq_count, 2);
      check("mid_busy_pre", busy, 8'h80);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_we", rf_we, 0);
      check("mid_rst_count", lq_count, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ld_ready", ld_ready, 1);
      issue_valid = 1; issue_addr = 6;
      step();
      check("mid_rst_no_push", lq_count, 0);
      check("mid_rst_no_issue", busy, 0);
      idle_inputs();
      #2 reset_n = 1'b1;
      step();

      // sticky error flag on a commit to r6 with nothing pending
      alu_valid = 1; alu_addr = 6; alu_data = 16'h6666;
      step();
      alu_valid = 0;
      check("err_before_commit", wb_err, 0);
      step();
      check("err_set", wb_err, 1);
      step(); step();
      check("err_sticky", wb_err, 1);
      apply_reset();
      check("err_cleared", wb_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
